xgemac_wb_master: RTL and testbench
===================================

XGEMAC_WB_MASTER -- requirements
Module: xgemac_wb_master

Interface
REQ-001 SHALL have parameter WB_ADDR_WIDTH, default 8, Wishbone address width.
REQ-002 SHALL have parameter WB_DATA_WIDTH, default 32, Wishbone data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum cycles waiting for ack (legal range 2..255).
REQ-004 SHALL use one clock and a synchronous, active-high reset; all state updates on the rising edge of wb_clk_i.
REQ-005 wb_clk_i  in  1  block clock.
REQ-006 wb_rst_i  in  1  synchronous active-high reset.
REQ-007 cmd_valid  in  1  command request; cmd_ready  out  1  command accepted when both high.
REQ-008 cmd_we  in  1  1=write, 0=read; cmd_addr  in  WB_ADDR_WIDTH; cmd_wdata  in  WB_DATA_WIDTH.
REQ-009 rsp_valid  out  1  response available; rsp_ready  in  1  response consumed when both high.
REQ-010 rsp_rdata  out  WB_DATA_WIDTH  read data (0 for writes and timeouts); rsp_err  out  1  timeout flag.
REQ-011 wb_adr_o, wb_dat_o  out  WB_ADDR_WIDTH / WB_DATA_WIDTH; wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone master signals to the MAC slave.
REQ-012 wb_ack_i  in  1; wb_dat_i  in  WB_DATA_WIDTH; wb_int_i  in  1  MAC interrupt.
REQ-013 int_pending  out  1  latched interrupt; int_clr  in  1  clear pulse; int_count  out  8  saturating interrupt-edge count.

Function
REQ-014 SHALL implement FSM states IDLE, BUS, RESP; all Wishbone and rsp outputs registered.
REQ-015 IDLE: cmd_ready=1; on cmd_valid, capture we/addr/wdata, go BUS; wb_cyc_o=wb_stb_o=1 from next cycle.
REQ-016 BUS: cmd_ready=0; wb_cyc_o, wb_stb_o, wb_adr_o, wb_dat_o, wb_we_o held stable until termination.
REQ-017 BUS, wb_ack_i sampled high: deassert cyc/stb at that edge, capture wb_dat_i if read (else 0), rsp_err=0, go RESP.
REQ-018 BUS: wait counter clears on entry, increments each cycle without ack; at TIMEOUT_CYCLES-1 without ack, deassert cyc/stb, rsp_rdata=0, rsp_err=1, go RESP.
REQ-019 Ack and timeout on the same edge: ack wins (rsp_err=0).
REQ-020 RESP: rsp_valid=1, rsp_rdata/rsp_err held until rsp_ready; then go IDLE, rsp_valid=0 next cycle.
REQ-021 Minimum latency: accept edge N, cyc/stb high N+1, ack at N+1 edge, rsp_valid high N+2; one transaction outstanding max.
REQ-022 wb_ack_i in IDLE or RESP SHALL be ignored.
REQ-023 int_pending SHALL set on wb_int_i rising edge (registered previous value); int_clr clears; set wins on simultaneous set/clear.
REQ-024 int_count SHALL increment per wb_int_i rising edge, saturate at 255, clear on int_clr unless an edge occurs in the same cycle (then becomes 1).

Reset
REQ-025 Reset SHALL force IDLE; cmd_ready=1 is reported only from the first cycle after reset release (0 during reset).
REQ-026 Reset values: wb_cyc_o, wb_stb_o, wb_we_o=0; wb_adr_o, wb_dat_o=0; rsp_valid, rsp_err=0; rsp_rdata=0; int_pending=0; int_count=0; wait counter=0; wb_int_i history=0.
REQ-027 Reset mid-BUS or mid-RESP SHALL drop cyc/stb at the reset edge and discard the pending response.

Structure
REQ-028 Package xgemac_wb_pkg SHALL hold the FSM state enum and default width/timeout constants.
REQ-029 Single module; no sub-module required.

Verification
REQ-030 Write addr 0x00 data 0x0000_0005, slave acks 1 cycle after stb -> cyc/stb high 2 cycles with we=1, rsp_valid, rsp_err=0, rsp_rdata=0.
REQ-031 Read addr 0x08, slave acks after 3 wait cycles with 0xDEAD_BEEF -> rsp_rdata=0xDEAD_BEEF, rsp_err=0, bus outputs stable throughout.
REQ-032 Read with no ack, TIMEOUT_CYCLES=16 -> cyc/stb deassert after exactly 16 BUS cycles, rsp_err=1, rsp_rdata=0.
REQ-033 rsp_ready held low 5 cycles -> rsp_valid/data stable, cmd_ready=0, new cmd_valid not accepted until response consumed.
REQ-034 wb_rst_i asserted while in BUS -> cyc/stb=0 next edge, no rsp_valid, cmd_ready=1 after release.
REQ-035 wb_int_i 3 pulses, then int_clr coincident with 4th rising edge -> int_count 3 then 1, int_pending stays 1.

Source files
------------

// File: rtl/xgemac_wb_pkg.sv
// Shared types and default sizing for the XGEMAC Wishbone command master.
package xgemac_wb_pkg;

  localparam int WB_ADDR_WIDTH_DEF  = 8;
  localparam int WB_DATA_WIDTH_DEF  = 32;
  localparam int TIMEOUT_CYCLES_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } wbm_state_e;

endpackage

// File: rtl/xgemac_wb_master.sv
// Single-outstanding Wishbone master bridging a valid/ready command/response
// pair to the MAC register slave, with ack timeout and interrupt latching.
module xgemac_wb_master
  import xgemac_wb_pkg::*;
#(
  parameter int WB_ADDR_WIDTH  = WB_ADDR_WIDTH_DEF,
  parameter int WB_DATA_WIDTH  = WB_DATA_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_we,
  input  logic [WB_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [WB_DATA_WIDTH-1:0] cmd_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WB_DATA_WIDTH-1:0] rsp_rdata,
  output logic                     rsp_err,
  output logic [WB_ADDR_WIDTH-1:0] wb_adr_o,
  output logic [WB_DATA_WIDTH-1:0] wb_dat_o,
  output logic                     wb_cyc_o,
  output logic                     wb_stb_o,
  output logic                     wb_we_o,
  input  logic                     wb_ack_i,
  input  logic [WB_DATA_WIDTH-1:0] wb_dat_i,
  input  logic                     wb_int_i,
  output logic                     int_pending,
  input  logic                     int_clr,
  output logic [7:0]               int_count
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  wbm_state_e               state, state_n;
  logic [7:0]               wait_cnt, wait_cnt_n;
  logic                     cmd_ready_n;
  logic                     rsp_valid_n, rsp_err_n;
  logic [WB_DATA_WIDTH-1:0] rsp_rdata_n;
  logic [WB_ADDR_WIDTH-1:0] wb_adr_n;
  logic [WB_DATA_WIDTH-1:0] wb_dat_n;
  logic                     wb_cyc_n, wb_stb_n, wb_we_n;

  logic                     int_prev;
  logic                     int_rise;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
    end else begin
      state     <= state_n;
      wait_cnt  <= wait_cnt_n;
      cmd_ready <= cmd_ready_n;
      rsp_valid <= rsp_valid_n;
      rsp_err   <= rsp_err_n;
      rsp_rdata <= rsp_rdata_n;
      wb_adr_o  <= wb_adr_n;
      wb_dat_o  <= wb_dat_n;
      wb_cyc_o  <= wb_cyc_n;
      wb_stb_o  <= wb_stb_n;
      wb_we_o   <= wb_we_n;
    end
  end

  always_comb begin
    state_n     = state;
    wait_cnt_n  = wait_cnt;
    rsp_valid_n = rsp_valid;
    rsp_err_n   = rsp_err;
    rsp_rdata_n = rsp_rdata;
    wb_adr_n    = wb_adr_o;
    wb_dat_n    = wb_dat_o;
    wb_cyc_n    = wb_cyc_o;
    wb_stb_n    = wb_stb_o;
    wb_we_n     = wb_we_o;
    unique case (state)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_n    = ST_BUS;
          wait_cnt_n = '0;
          wb_cyc_n   = 1'b1;
          wb_stb_n   = 1'b1;
          wb_we_n    = cmd_we;
          wb_adr_n   = cmd_addr;
          wb_dat_n   = cmd_wdata;
        end
      end
      ST_BUS: begin
        // Ack is tested first so an ack on the timeout edge still succeeds.
        if (wb_ack_i) begin
          state_n     = ST_RESP;
          wb_cyc_n    = 1'b0;
          wb_stb_n    = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b0;
          rsp_rdata_n = wb_we_o ? '0 : wb_dat_i;
        end else if (wait_cnt == WAIT_LAST) begin
          state_n     = ST_RESP;
          wb_cyc_n    = 1'b0;
          wb_stb_n    = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b1;
          rsp_rdata_n = '0;
        end else begin
          wait_cnt_n = wait_cnt + 8'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_n     = ST_IDLE;
          rsp_valid_n = 1'b0;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    cmd_ready_n = (state_n == ST_IDLE);
  end

  assign int_rise = wb_int_i & ~int_prev;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      int_prev    <= 1'b0;
      int_pending <= 1'b0;
      int_count   <= '0;
    end else begin
      int_prev <= wb_int_i;
      if (int_rise)     int_pending <= 1'b1;
      else if (int_clr) int_pending <= 1'b0;
      if (int_rise) begin
        if (int_clr)                int_count <= 8'd1;
        else if (int_count != '1)   int_count <= int_count + 8'd1;
      end else if (int_clr) begin
        int_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_xgemac_wb_master.sv
// Randomised self-checking bench for xgemac_wb_master against a transaction-level model.
module tb_xgemac_wb_master;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o, wb_dat_i;
  logic          wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
  logic          wb_int_i, int_pending, int_clr;
  logic [7:0]    int_count;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Interrupt reference state
  bit          m_prev, m_pend;
  int unsigned m_cnt;

  always #5 wb_clk_i = ~wb_clk_i;

  xgemac_wb_master #(
    .WB_ADDR_WIDTH (AW),
    .WB_DATA_WIDTH (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_we     (cmd_we),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wb_ack_i   (wb_ack_i),
    .wb_dat_i   (wb_dat_i),
    .wb_int_i   (wb_int_i),
    .int_pending(int_pending),
    .int_clr    (int_clr),
    .int_count  (int_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    repeat (2) @(negedge wb_clk_i);
    check("rst_cyc", 32'(wb_cyc_o), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_cmd_ready", 32'(cmd_ready), 0);
    wb_rst_i = 1'b0;
    m_prev = 0; m_pend = 0; m_cnt = 0;
  endtask

  task automatic wait_ready();
    int unsigned n = 0;
    while (!cmd_ready && n < 10) begin
      @(negedge wb_clk_i);
      n++;
    end
    check("cmd_ready_timeout", 32'(cmd_ready), 1);
  endtask

  // One command: slave acks after ack_wait non-acked BUS cycles (>= TO means never);
  // the response is left unconsumed for hold cycles.
  task automatic do_txn(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [DW-1:0] rdata, input int unsigned ack_wait,
                        input int unsigned hold);
    int unsigned   n;
    int unsigned   exp_cycles;
    bit            exp_err;
    logic [DW-1:0] exp_data;
    exp_err    = (ack_wait >= TO);
    exp_cycles = exp_err ? TO : ack_wait + 1;
    exp_data   = (exp_err || we) ? '0 : rdata;
    wait_ready();
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata;
    wb_ack_i  = 1'b0;
    @(negedge wb_clk_i);
    cmd_valid = 1'b0;
    cmd_wdata = ~wdata;
    cmd_addr  = ~addr;
    n = 0;
    while (wb_cyc_o && n < 40) begin
      check("bus_stb", 32'(wb_stb_o), 1);
      check("bus_we", 32'(wb_we_o), 32'(we));
      check("bus_adr", 32'(wb_adr_o), 32'(addr));
      check("bus_dat", wb_dat_o, wdata);
      check("bus_no_rsp", 32'(rsp_valid), 0);
      wb_ack_i = (n == ack_wait);
      wb_dat_i = (n == ack_wait) ? rdata : DW'($urandom);
      @(negedge wb_clk_i);
      n++;
    end
    wb_ack_i = 1'b0;
    check("bus_cycles", n, exp_cycles);
    check("stb_drop", 32'(wb_stb_o), 0);
    check("rsp_valid", 32'(rsp_valid), 1);
    check("rsp_err", 32'(rsp_err), 32'(exp_err));
    check("rsp_rdata", rsp_rdata, exp_data);
    for (int unsigned h = 0; h < hold; h++) begin
      cmd_valid = 1'b1;
      cmd_we    = $urandom_range(0, 1);
      wb_ack_i  = $urandom_range(0, 1);
      wb_dat_i  = DW'($urandom);
      @(negedge wb_clk_i);
      check("hold_valid", 32'(rsp_valid), 1);
      check("hold_err", 32'(rsp_err), 32'(exp_err));
      check("hold_rdata", rsp_rdata, exp_data);
      check("hold_cmd_ready", 32'(cmd_ready), 0);
      check("hold_no_cyc", 32'(wb_cyc_o), 0);
    end
    cmd_valid = 1'b0;
    wb_ack_i  = 1'b0;
    rsp_ready = 1'b1;
    @(negedge wb_clk_i);
    rsp_ready = 1'b0;
    check("rsp_consumed", 32'(rsp_valid), 0);
    check("post_cmd_ready", 32'(cmd_ready), 1);
    check("post_no_cyc", 32'(wb_cyc_o), 0);
  endtask

  // Drive one cycle of interrupt inputs and compare against the edge-count rules.
  task automatic int_step(input bit irq, input bit clr);
    bit rise;
    wb_int_i = irq;
    int_clr  = clr;
    @(posedge wb_clk_i);
    rise = irq && !m_prev;
    if (rise) begin
      m_pend = 1;
      m_cnt  = clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
    end else if (clr) begin
      m_pend = 0;
      m_cnt  = 0;
    end
    m_prev = irq;
    @(negedge wb_clk_i);
    check("int_pending", 32'(int_pending), 32'(m_pend));
    check("int_count", 32'(int_count), m_cnt);
  endtask

  initial begin
    wb_rst_i = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; wb_ack_i = 1'b0; wb_dat_i = '0; wb_int_i = 1'b0; int_clr = 1'b0;
    do_reset();
    check("rst_adr", 32'(wb_adr_o), 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_int_count", 32'(int_count), 0);
    repeat (2) @(negedge wb_clk_i);
    check("ready_after_rst", 32'(cmd_ready), 1);

    do_txn(1'b1, 8'h00, 32'h0000_0005, 32'h1234_5678, 1, 0);
    do_txn(1'b0, 8'h08, 32'h0000_0000, 32'hDEAD_BEEF, 3, 0);
    do_txn(1'b0, 8'h10, 32'h0000_0000, 32'hAAAA_5555, 100, 0);
    do_txn(1'b0, 8'h14, 32'h0, 32'hCAFE_F00D, TO - 1, 1);
    do_txn(1'b0, 8'h18, 32'h0, 32'h0BAD_F00D, 0, 5);

    for (int i = 0; i < 40; i++) begin
      int unsigned w;
      w = ($urandom_range(0, 7) == 0) ? $urandom_range(TO, TO + 4) : $urandom_range(0, TO - 1);
      do_txn(1'($urandom), AW'($urandom), DW'($urandom), DW'($urandom), w,
             $urandom_range(0, 4));
    end

    // Reset while the bus cycle is waiting for an ack.
    wait_ready();
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 8'h20;
    @(negedge wb_clk_i);
    cmd_valid = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    check("mid_bus_cyc", 32'(wb_cyc_o), 1);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    check("rst_bus_cyc", 32'(wb_cyc_o), 0);
    check("rst_bus_stb", 32'(wb_stb_o), 0);
    check("rst_bus_rsp", 32'(rsp_valid), 0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    m_prev = 0; m_pend = 0; m_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge wb_clk_i);
      check("rst_bus_no_rsp", 32'(rsp_valid), 0);
    end
    check("rst_bus_ready", 32'(cmd_ready), 1);
    do_txn(1'b1, 8'h04, 32'h5A5A_A5A5, 32'h0, 2, 1);

    // Three interrupt pulses, then clear coincident with the fourth rising edge.
    for (int p = 0; p < 3; p++) begin
      int_step(1'b1, 1'b0);
      int_step(1'b0, 1'b0);
    end
    check("int_count_3", 32'(int_count), 3);
    int_step(1'b1, 1'b1);
    check("int_count_1", 32'(int_count), 1);
    check("int_pending_kept", 32'(int_pending), 1);
    int_step(1'b1, 1'b1);
    int_step(1'b0, 1'b0);

    // Saturation: more than 255 edges without a clear.
    for (int i = 0; i < 270; i++) begin
      int_step(1'b1, 1'b0);
      int_step(1'b0, 1'b0);
    end
    check("int_saturated", 32'(int_count), 255);

    for (int i = 0; i < 300; i++)
      int_step(1'($urandom), ($urandom_range(0, 9) == 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

endmodule
